// File: rtl/multi_edge_detector.sv
// multi_edge_detector: multi-channel synchronised, debounced edge detector with per-channel edge mode and sticky pending flags
module multi_edge_detector #(
  parameter int CHANNELS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int TICK_DIV       = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic                  any_pulse
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = DEBOUNCE_TICKS > 1 ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_TICKS - 1);
  logic [PW-1:0] r_pre;
  logic w_tick;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0] w_sync, r_stable, r_pulse, r_pending, w_accept, w_pulse_set;
  logic [CW-1:0] r_cnt [CHANNELS];
  assign w_tick    = r_pre == PRE_MAX;
  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign level     = r_stable;
  assign pulse     = r_pulse;
  assign pending   = r_pending;
  assign any_pulse = |r_pulse;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_accept[i]    = w_tick && (w_sync[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
    assign w_pulse_set[i] = w_accept[i] && (w_sync[i] ? mode[2*i] : mode[2*i+1]);
  end
  // Sample-tick prescaler; with TICK_DIV=1 the counter sits at 0 and tick stays high
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_pre <= '0;
    else r_pre <= w_tick ? '0 : r_pre + 1'b1;
  // Synchroniser shift chain, stage 0 captures the raw pins
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], signal};
  // Debounce: a mismatch must persist for DEBOUNCE_TICKS ticks before the new level is accepted
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_stable <= '0;
      for (int k = 0; k < CHANNELS; k++) r_cnt[k] <= '0;
    end else
      for (int k = 0; k < CHANNELS; k++)
        if (w_sync[k] == r_stable[k]) r_cnt[k] <= '0;
        else if (w_accept[k]) begin
          r_stable[k] <= w_sync[k];
          r_cnt[k]    <= '0;
        end else if (w_tick) r_cnt[k] <= r_cnt[k] + 1'b1;
  // Event pulse on accepted edges matching the mode; pending is sticky and a new event beats clr
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_pulse   <= '0;
      r_pending <= '0;
    end else begin
      r_pulse   <= w_pulse_set;
      r_pending <= w_pulse_set | (r_pending & ~clr);
    end
endmodule

// File: tb/tb_multi_edge_detector.sv
// tb_multi_edge_detector: directed checks of the default-parameter detector and a TICK_DIV=3 / DEBOUNCE_TICKS=2 instance
module tb_multi_edge_detector;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] sig = '0, clr = '0, lvl, pls, pnd;
  logic [7:0] mode = '0;
  logic anyp;
  logic [0:0] sig1 = '0, lvl1, pls1, pnd1;
  logic anyp1;
  int checks = 0, errors = 0, cyc = 0, s, e;
  multi_edge_detector dut (
    .clk(clk), .reset_n(reset_n), .signal(sig), .mode(mode), .clr(clr),
    .level(lvl), .pulse(pls), .pending(pnd), .any_pulse(anyp)
  );
  multi_edge_detector #(.CHANNELS(1), .SYNC_STAGES(2), .DEBOUNCE_TICKS(2), .TICK_DIV(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .signal(sig1), .mode(2'b11), .clr(1'b0),
    .level(lvl1), .pulse(pls1), .pending(pnd1), .any_pulse(anyp1)
  );
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Ticks of the divided instance land on edges where cyc%3==0 (cyc counts edges since reset release).
  // Input set at cyc s is synchronised after edge s+2; two ticks at or after edge s+3 accept it.
  function automatic int accept_at(input int st);
    int t = st + 3;
    while (t % 3 != 0) t++;
    return t + 3;
  endfunction
  initial begin
    step(2);
    chk("rst level", lvl, 0);
    chk("rst pulse", pls, 0);
    chk("rst pending", pnd, 0);
    chk("rst any", anyp, 0);
    chk("rst level1", lvl1, 0);
    chk("rst pulse1", pls1, 0);
    reset_n = 1'b1;
    cyc = 0;
    mode = 8'b00_10_11_01;
    sig[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("rise wait level0", lvl[0], 0);
      chk("rise wait pulse", pls, 0);
    end
    step(1);
    chk("rise level0", lvl[0], 1);
    chk("rise pulse", pls, 4'b0001);
    chk("rise pending", pnd, 4'b0001);
    chk("rise any", anyp, 1);
    step(1);
    chk("rise pulse one cycle", pls, 0);
    chk("rise any low", anyp, 0);
    chk("rise level held", lvl[0], 1);
    sig[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("fall wait level0", lvl[0], 1);
      chk("fall wait pulse", pls, 0);
    end
    step(1);
    chk("fall level0", lvl[0], 0);
    chk("fall no pulse mode01", pls, 0);
    chk("pending sticky", pnd[0], 1);
    clr[0] = 1'b1;
    step(1);
    chk("clr pending", pnd, 0);
    clr = '0;
    for (int k = 0; k < 4; k++) begin
      sig[1] = (k % 2 == 0);
      step(1);
      chk("bounce pulse", pls, 0);
      chk("bounce level", lvl[1], 0);
    end
    sig[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("bounce settle pulse", pls, 0);
      chk("bounce settle level", lvl[1], 0);
    end
    step(1);
    chk("bounce pulse", pls, 4'b0010);
    chk("bounce level", lvl[1], 1);
    step(1);
    chk("bounce single pulse", pls, 0);
    sig[3:2] = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("mode rise no pulse", pls, 0);
    end
    chk("mode level rise", lvl[3:2], 2'b11);
    sig[3:2] = 2'b00;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("mode fall wait pulse", pls, 0);
    end
    step(1);
    chk("mode fall pulse ch2 only", pls, 4'b0100);
    chk("mode level fall", lvl[3:2], 2'b00);
    chk("mode pending", pnd, 4'b0110);
    mode = 8'hFF;
    step(2);
    chk("mode change no pulse", pls, 0);
    mode = 8'b00_10_11_01;
    clr = 4'hF;
    step(1);
    chk("clr all", pnd, 0);
    clr = '0;
    sig[0] = 1'b1;
    step(5);
    clr[0] = 1'b1;
    step(1);
    chk("set beats clr pulse", pls, 4'b0001);
    chk("set beats clr pending", pnd, 4'b0001);
    step(1);
    chk("clr after pulse", pnd, 0);
    chk("clr after pulse no pulse", pls, 0);
    clr = '0;
    s = cyc;
    e = accept_at(s);
    sig1 = 1'b1;
    while (cyc < e - 1) begin
      step(1);
      chk("div rise wait level", lvl1, 0);
      chk("div rise wait pulse", pls1, 0);
    end
    step(1);
    chk("div rise level", lvl1, 1);
    chk("div rise pulse", pls1, 1);
    step(1);
    chk("div rise pulse one cycle", pls1, 0);
    sig1 = 1'b0;
    step(1);
    sig1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("div glitch level", lvl1, 1);
      chk("div glitch pulse", pls1, 0);
    end
    s = cyc;
    e = accept_at(s);
    sig1 = 1'b0;
    while (cyc < e - 1) begin
      step(1);
      chk("div fall wait level", lvl1, 1);
    end
    step(1);
    chk("div fall level", lvl1, 0);
    chk("div fall pulse", pls1, 1);
    sig[0] = 1'b0;
    step(4);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst level", lvl, 0);
    chk("async rst pulse", pls, 0);
    chk("async rst pending", pnd, 0);
    chk("async rst any", anyp, 0);
    sig = 4'b0001;
    step(1);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("post rst wait level", lvl, 0);
      chk("post rst wait pulse", pls, 0);
    end
    step(1);
    chk("post rst level", lvl, 4'b0001);
    chk("post rst pulse", pls, 4'b0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel debounced edge detector. It replaces single-channel, divided-clock edge detection: one clock domain plus an internal sample-tick prescaler. Each channel has its own synchroniser, its own debounce counter and a per-channel edge mode. Sits between raw pushbutton/switch pins and the control FSMs, which consume single-cycle event pulses or sticky pending flags.

## Interface
Parameters:
- CHANNELS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DEBOUNCE_TICKS, 4, consecutive mismatching ticks required to accept a new level (≥1)
- TICK_DIV, 1, clk cycles per sample tick (≥1; 1 = every cycle)

Ports:
- clk  input  1  system clock; all state on posedge
- reset_n  input  1  asynchronous, active-low reset
- signal  input  CHANNELS  raw asynchronous inputs
- mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clr  input  CHANNELS  per-channel clear of pending flag
- level  output  CHANNELS  debounced level
- pulse  output  CHANNELS  one-clk event pulse per accepted edge matching mode
- pending  output  CHANNELS  sticky event flags
- any_pulse  output  1  OR of pulse

## Operation
- Prescaler: counter 0..TICK_DIV-1, wraps; tick asserted in the cycle where counter == TICK_DIV-1. With TICK_DIV=1, tick is constantly 1.
- Synchroniser: signal[i] passes through SYNC_STAGES flops, giving sync[i].
- Debounce, per channel: stable[i] (drives level[i]) and cnt[i], width clog2(DEBOUNCE_TICKS), min 1.
  - On any cycle with sync==stable: cnt <= 0.
  - On a tick with sync!=stable and cnt < DEBOUNCE_TICKS-1: cnt <= cnt+1.
  - On a tick with sync!=stable and cnt == DEBOUNCE_TICKS-1: stable <= sync, cnt <= 0.
  - Non-tick cycles with a mismatch hold cnt.
- Edge event: rise = stable updates 0→1; fall = stable updates 1→0.
- pulse[i] is registered and set on the same edge stable updates when:
  - mode 01 and rise, or
  - mode 10 and fall, or
  - mode 11 and either.
  - Mode 00 never pulses.
- Every pulse is exactly one clk cycle; there is no re-trigger while the level holds.
- pending[i]: set by pulse[i]; cleared by clr[i] when no pulse is being set; simultaneous set and clr leaves pending = 1 (set wins).
- mode is read live every cycle. A mode change alone never produces a pulse; it only affects subsequent accepted edges. level tracks regardless of mode.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.

## Timing
- Reset (reset_n low, asynchronous): sync flops, stable, cnt, prescaler, pulse, pending all 0. Therefore level = 0, pulse = 0, pending = 0, any_pulse = 0.
- Reset mid-debounce discards partial counts. An input held high through reset release is accepted as a rising edge after full latency.
- Latency with TICK_DIV=1: input steady before posedge 0 → level and pulse high after posedge SYNC_STAGES+DEBOUNCE_TICKS-1 (defaults: after posedge 5).
- Latency with TICK_DIV>1: after synchronisation, DEBOUNCE_TICKS further ticks; worst case adds up to TICK_DIV-1 cycles of phase.
- Glitch rejection: any return to sync==stable before the final tick resets cnt. A glitch shorter than DEBOUNCE_TICKS ticks never changes level.
- any_pulse is combinational OR of registered pulse; no extra latency.

## Test plan
- Defaults, ch0 mode 01: signal[0] 0→1 before edge 0, held → level[0] and pulse[0] rise after edge 5; pulse[0] is 1 for one cycle; pending[0]=1; releasing → level falls after 5 edges, no pulse.
- Bounce: signal[1] toggles 1,0,1,0 on alternate cycles, then held 1, mode 11 → exactly one pulse, 5 edges after the final transition; no pulse during bounce.
- Modes: ch2 mode 10, ch3 mode 00, both given 0→1→0 → ch2 pulses only on fall; ch3 never pulses; level[3] still tracks.
- pending/clr: pulse on ch0 with clr[0]=1 in the same cycle → pending[0] stays 1; clr next cycle → pending[0]=0.
- TICK_DIV=3, DEBOUNCE_TICKS=2: step input → level changes only on tick cycles, within 2+2*3+2 edges; 1-cycle glitch → no change.
- Async reset: assert reset_n=0 mid-count (cnt=2) → all outputs 0 immediately; release with input high → rising pulse after full latency.
